// File: rtl/reg_file_wr_arbiter.sv
// Round-robin arbiter sharing the single register-file write port.
// One registered write pulse and one-cycle ack per grant, then a RELEASE cycle before re-arbitration.
module reg_file_wr_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      areset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          ack,
    output logic                      rf_wr_en,
    output logic [ADDR_W-1:0]         rf_wr_addr,
    output logic [DATA_W-1:0]         rf_wr_data,
    output logic                      busy
);

    localparam int PTR_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [PTR_W-1:0]    ptr, ptr_n;
    logic [PTR_W-1:0]    win, cand;
    logic                found;
    int                  idx;

    logic [N_REQ-1:0]    ack_n;
    logic                wr_en_n;
    logic [ADDR_W-1:0]   wr_addr_n;
    logic [DATA_W-1:0]   wr_data_n;
    logic                busy_n;

    // First asserted request searching from ptr upward, wrapping mod N_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            cand = PTR_W'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state      <= IDLE;
            ptr        <= '0;
            ack        <= '0;
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            ack        <= ack_n;
            rf_wr_en   <= wr_en_n;
            rf_wr_addr <= wr_addr_n;
            rf_wr_data <= wr_data_n;
            busy       <= busy_n;
        end
    end

    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE:    state_n = found ? WRITE : IDLE;
            WRITE:   state_n = RELEASE;
            RELEASE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ack_n     = '0;
        wr_en_n   = 1'b0;
        wr_addr_n = rf_wr_addr;
        wr_data_n = rf_wr_data;
        busy_n    = 1'b0;
        ptr_n     = ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    wr_en_n    = 1'b1;
                    ack_n[win] = 1'b1;
                    wr_addr_n  = req_addr[int'(win)*ADDR_W +: ADDR_W];
                    wr_data_n  = req_data[int'(win)*DATA_W +: DATA_W];
                    busy_n     = 1'b1;
                    ptr_n      = (win == PTR_W'(N_REQ-1)) ? '0 : win + 1'b1;
                end
            end
            WRITE:   busy_n = 1'b1;
            // RELEASE ignores req so a request still high in the ack cycle is not regranted.
            RELEASE: busy_n = 1'b0;
            default: begin
                wr_addr_n = '0;
                wr_data_n = '0;
                ptr_n     = ptr;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// Directed bench for reg_file_wr_arbiter with N_REQ=2, ADDR_W=4, DATA_W=32.
module tb_reg_file_wr_arbiter;

    logic        clk = 1'b0;
    logic        areset;
    logic [1:0]  req;
    logic [7:0]  req_addr;
    logic [63:0] req_data;
    logic [1:0]  ack;
    logic        rf_wr_en;
    logic [3:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    reg_file_wr_arbiter #(.N_REQ(2), .ADDR_W(4), .DATA_W(32)) dut (
        .clk        (clk),
        .areset     (areset),
        .req        (req),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .ack        (ack),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic en, input logic [1:0] a,
                           input logic [3:0] ad, input logic [31:0] d, input logic b);
        chk({tag, ".rf_wr_en"},   64'(rf_wr_en),   64'(en));
        chk({tag, ".ack"},        64'(ack),        64'(a));
        chk({tag, ".rf_wr_addr"}, 64'(rf_wr_addr), 64'(ad));
        chk({tag, ".rf_wr_data"}, 64'(rf_wr_data), 64'(d));
        chk({tag, ".busy"},       64'(busy),       64'(b));
    endtask

    initial begin
        // 1. Reset held with both requests high
        areset   = 1'b1;
        req      = 2'b11;
        req_addr = {4'h2, 4'h1};
        req_data = {32'h22, 32'h11};
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("reset_hold", 1'b0, 2'b00, 4'h0, 32'h0, 1'b0);
        end
        areset = 1'b0;
        step();
        chk_out("reset_first_grant", 1'b1, 2'b01, 4'h1, 32'h11, 1'b1);
        req = 2'b00;
        step();
        chk_out("reset_write", 1'b0, 2'b00, 4'h1, 32'h11, 1'b1);
        step();
        chk_out("reset_release", 1'b0, 2'b00, 4'h1, 32'h11, 1'b0);

        // 2. Single requester 1 (ptr is now 1)
        req_addr = {4'h3, 4'h1};
        req_data = {32'hDEADBEEF, 32'h11};
        req      = 2'b10;
        step();
        chk_out("single_grant", 1'b1, 2'b10, 4'h3, 32'hDEADBEEF, 1'b1);
        req = 2'b00;
        step();
        chk_out("single_write", 1'b0, 2'b00, 4'h3, 32'hDEADBEEF, 1'b1);
        step();
        chk_out("single_release", 1'b0, 2'b00, 4'h3, 32'hDEADBEEF, 1'b0);
        step();
        chk_out("single_idle", 1'b0, 2'b00, 4'h3, 32'hDEADBEEF, 1'b0);

        // 3. Contention: grants alternate 0,1,0,1 every 3 cycles
        req_addr = {4'h2, 4'h1};
        req_data = {32'h22, 32'h11};
        req      = 2'b11;
        for (int g = 0; g < 4; g++) begin
            logic [1:0]  exp_ack;
            logic [3:0]  exp_ad;
            logic [31:0] exp_d;
            exp_ack = (g % 2 == 0) ? 2'b01 : 2'b10;
            exp_ad  = (g % 2 == 0) ? 4'h1 : 4'h2;
            exp_d   = (g % 2 == 0) ? 32'h11 : 32'h22;
            step();
            chk_out($sformatf("contend_grant%0d", g), 1'b1, exp_ack, exp_ad, exp_d, 1'b1);
            req = req & ~exp_ack;
            step();
            chk_out($sformatf("contend_write%0d", g), 1'b0, 2'b00, exp_ad, exp_d, 1'b1);
            req = 2'b11;
            step();
            chk_out($sformatf("contend_release%0d", g), 1'b0, 2'b00, exp_ad, exp_d, 1'b0);
        end
        req = 2'b00;
        step();
        chk_out("contend_idle", 1'b0, 2'b00, 4'h2, 32'h22, 1'b0);

        // 4. Requester 0 holds req two cycles past its ack (ptr is 0)
        req = 2'b01;
        step();
        chk_out("held_grant", 1'b1, 2'b01, 4'h1, 32'h11, 1'b1);
        step();
        chk_out("held_write", 1'b0, 2'b00, 4'h1, 32'h11, 1'b1);
        step();
        chk_out("held_release", 1'b0, 2'b00, 4'h1, 32'h11, 1'b0);
        req = 2'b00;
        step();
        chk_out("held_no_regrant", 1'b0, 2'b00, 4'h1, 32'h11, 1'b0);

        // 5. Reset in the write-pulse cycle (ptr is 1 before it)
        req = 2'b01;
        step();
        chk_out("midrst_grant", 1'b1, 2'b01, 4'h1, 32'h11, 1'b1);
        areset = 1'b1;
        req    = 2'b00;
        step();
        chk_out("midrst_cleared", 1'b0, 2'b00, 4'h0, 32'h0, 1'b0);
        areset = 1'b0;
        // Winner 0 here means ptr returned to 0; a stale ptr of 1 would pick requester 1
        req = 2'b11;
        step();
        chk_out("midrst_ptr0", 1'b1, 2'b01, 4'h1, 32'h11, 1'b1);
        req = 2'b10;
        step();
        chk_out("midrst_write", 1'b0, 2'b00, 4'h1, 32'h11, 1'b1);
        step();
        chk_out("midrst_release", 1'b0, 2'b00, 4'h1, 32'h11, 1'b0);
        step();
        chk_out("midrst_req1_grant", 1'b1, 2'b10, 4'h2, 32'h22, 1'b1);
        req = 2'b00;
        step();
        step();
        chk_out("midrst_done", 1'b0, 2'b00, 4'h2, 32'h22, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_wr_arbiter.md
# reg_file_wr_arbiter

Round-robin arbiter that shares the single register-file write port between several write requesters: the AXI-lite write controller and on-chip hardware status updaters. It latches the winning request's address and data, drives one registered write pulse into the register file, and returns a one-cycle acknowledge to the winner. It sits between the requesters and the register file write port.

## Interface

Parameters:
- N_REQ, 2: number of requesters, 2 to 8.
- ADDR_W, 4: register-file address width.
- DATA_W, 32: register-file data width.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- areset  input  1  reset; synchronous and active-high.
- req  input  N_REQ  per-requester write request; bit i belongs to requester i.
- req_addr  input  N_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  input  N_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- ack  output  N_REQ  one-hot, one-cycle write-done pulse to the winner.
- rf_wr_en  output  1  register-file write enable.
- rf_wr_addr  output  ADDR_W  register-file write address.
- rf_wr_data  output  DATA_W  register-file write data.
- busy  output  1  high whenever the FSM is not in IDLE.

## Operation

- All outputs are registered. Next-state and next-output logic is combinational, and every output flops on clk.
- The round-robin pointer ptr ranges from 0 to N_REQ-1. Search order is ptr, ptr+1, … wrapping mod N_REQ. The first asserted req bit in that order wins.
- FSM states:
  - IDLE: if req == 0, stay in IDLE. Otherwise pick winner w and go to WRITE. On the same edge, register rf_wr_en=1, ack[w]=1, rf_wr_addr and rf_wr_data from requester w, busy=1, and set ptr=(w+1) mod N_REQ.
  - WRITE: unconditionally go to RELEASE. On this edge rf_wr_en and ack go to 0. rf_wr_addr and rf_wr_data hold their values. busy stays 1.
  - RELEASE: req is ignored. Go to IDLE, and busy goes to 0 on this edge.
  - Illegal or unused state encodings go to IDLE with all outputs at 0.
- Requester contract:
  - Hold req, addr and data stable from assertion until ack is seen.
  - Deassert req in the cycle after ack.
  - RELEASE exists so that a req still high during the ack cycle is not granted twice.
- ptr changes only on a grant. It does not change when req is idle.
- No combinational path from req to any output.

## Timing

- Reset values: state=IDLE, ptr=0, ack=0, rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, busy=0.
- Latency: req sampled high at edge k makes rf_wr_en and ack high for exactly the cycle between edges k and k+1.
- Throughput: at most one write per 3 cycles. The earliest next grant is at edge k+3.
- Simultaneous requests: exactly one winner per grant, chosen by ptr. The losers keep req high and are served in later rounds. No requester waits more than N_REQ grants.
- A req that rises while the FSM is in WRITE or RELEASE is sampled in the next IDLE cycle.
- Reset during WRITE or RELEASE: all outputs are 0 on the next edge. The in-flight ack is dropped, and that requester must retry. A write already visible on rf_wr_en in an earlier cycle is not undone.
- Wrap-around: a grant to requester N_REQ-1 sets ptr to 0.

## Test plan

All scenarios use N_REQ=2, ADDR_W=4, DATA_W=32.

1. **Reset:** hold areset high for 3 cycles with req=2'b11. Required: ack, rf_wr_en, busy, rf_wr_addr and rf_wr_data stay 0. After release, the first grant goes to requester 0.
2. **Single requester:** requester 1 raises req for addr 4'h3, data 32'hDEADBEEF at edge k. Required: rf_wr_en=1, ack=2'b10, rf_wr_addr=3 and rf_wr_data=DEADBEEF for one cycle after edge k. busy is low again after edge k+2.
3. **Contention and fairness:** req=2'b11 held continuously, with requester 0 at addr 1/data 32'h11 and requester 1 at addr 2/data 32'h22. The bench drops each requester's req after its ack and re-raises it 1 cycle later. Required: grants alternate 0,1,0,1 with a 3-cycle spacing.
4. **Held req across ack:** requester 0 keeps req high for 2 cycles after ack. Required: exactly one rf_wr_en pulse, because the RELEASE state suppresses a second grant.
5. **Reset mid-operation:** assert areset in the cycle rf_wr_en=1. Required: all outputs are 0 on the next edge and ptr is 0. Requester 1's following request is granted normally, 1 cycle after it is sampled.
